mtimer_slave: RTL

Memory-mapped machine timer that sits on the core's data-memory bus as a responder and drives the core's `timer_int` input. It holds a 64-bit free-running `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp` compare register. It raises `timer_int` while `mtime >= mtimecmp`. Reads return registered data one cycle after the request, with the same timing as the data RAM, so the core's load path needs no change.

---
 rtl/mtimer_pkg.sv | 69 ++++++
 rtl/mtimer_bus_if.sv | 73 +++++++
 rtl/mtimer_slave.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: shared constants and types for the memory-mapped machine timer.
//   - register offsets within the 32-byte window and their one-hot select indices
//   - RISC-V load/store funct3 encodings and access-size codes
//   - ctrl_t: layout of the CTRL register as seen on the bus
//   - byte-lane helpers used for partial stores
package mtimer_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned NUM_REGS = 5;

   // Byte offsets of the implemented registers.
   localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
   localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
   localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
   localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
   localparam logic [4:0] CTRL_OFF        = 5'h10;

   // Bit positions in the one-hot wr_en / rd_sel vectors.
   localparam int unsigned REG_MTIME_LO    = 0;
   localparam int unsigned REG_MTIME_HI    = 1;
   localparam int unsigned REG_MTIMECMP_LO = 2;
   localparam int unsigned REG_MTIMECMP_HI = 3;
   localparam int unsigned REG_CTRL        = 4;

   // funct3 encodings of loads/stores.
   typedef enum logic [2:0] {
      MEM_OP_B  = 3'b000,
      MEM_OP_H  = 3'b001,
      MEM_OP_W  = 3'b010,
      MEM_OP_BU = 3'b100,
      MEM_OP_HU = 3'b101
   } mem_op_e;

   // Access size taken from funct3[1:0].
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // CTRL layout: DIV starts at bit 8; up to 24 DIV bits fit in the word.
   localparam int unsigned CTRL_DIV_LSB   = 8;
   localparam int unsigned CTRL_DIV_MAX_W = 24;

   typedef struct packed {
      logic [CTRL_DIV_MAX_W-1:0] div;
      logic [6:0]                rsvd;
      logic                      en;
   } ctrl_t;

   // Replace the bytes of old_w selected by be with the matching bytes of new_w.
   function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                  input logic [WORD_W-1:0] new_w,
                                                  input logic [3:0]        be);
      logic [WORD_W-1:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      end
      return res;
   endfunction

   // Byte lanes of CTRL that hold at least one DIV bit for a given DIV width.
   function automatic logic [3:0] div_byte_mask(input int div_w);
      logic [3:0] m;
      for (int b = 0; b < 4; b++) begin
         m[b] = ((8*b + 7) >= int'(CTRL_DIV_LSB)) && ((8*b) <= int'(CTRL_DIV_LSB) + div_w - 1);
      end
      return m;
   endfunction

endpackage

// File: rtl/mtimer_bus_if.sv
// mtimer_bus_if: address decode and store formatting for the timer window.
//   addr, wdata, write, read, op : MEM-stage bus request
//   wr_en[4:0]    : one-hot register write strobe (hit, legal, aligned store)
//   be[3:0]       : byte enables of the store, 0 when the store is dropped
//   wdata_aligned : store data shifted onto its byte lane
//   rd_sel[4:0]   : one-hot register read select (hit load to an implemented register)
module mtimer_bus_if
   import mtimer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic [31:0]         addr,
   input  logic [31:0]         wdata,
   input  logic                write,
   input  logic                read,
   input  logic [2:0]          op,
   output logic [NUM_REGS-1:0] wr_en,
   output logic [3:0]          be,
   output logic [31:0]         wdata_aligned,
   output logic [NUM_REGS-1:0] rd_sel
);

   logic                hit;
   logic [1:0]          lane;
   logic [3:0]          be_raw;
   logic                misaligned;
   logic                illegal;
   logic                store_ok;
   logic [NUM_REGS-1:0] reg_sel;

   assign hit  = (addr[31:5] == BASE_ADDR[31:5]);
   assign lane = addr[1:0];

   // Byte enables and alignment from access size and low address bits.
   // funct3 with bit 2 set is only defined for loads, so such a store is dropped.
   always_comb begin
      be_raw     = 4'b0000;
      misaligned = 1'b0;
      illegal    = op[2];
      case (op[1:0])
         SIZE_B: be_raw = 4'b0001 << lane;
         SIZE_H: begin
            be_raw     = 4'b0011 << lane;
            misaligned = lane[0];
         end
         SIZE_W: begin
            be_raw     = 4'b1111;
            misaligned = (lane != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
   end

   // Word-offset decode; reserved offsets select nothing.
   always_comb begin
      reg_sel = '0;
      case ({addr[4:2], 2'b00})
         MTIME_LO_OFF:    reg_sel[REG_MTIME_LO]    = 1'b1;
         MTIME_HI_OFF:    reg_sel[REG_MTIME_HI]    = 1'b1;
         MTIMECMP_LO_OFF: reg_sel[REG_MTIMECMP_LO] = 1'b1;
         MTIMECMP_HI_OFF: reg_sel[REG_MTIMECMP_HI] = 1'b1;
         CTRL_OFF:        reg_sel[REG_CTRL]        = 1'b1;
         default:         reg_sel = '0;
      endcase
   end

   assign store_ok      = write && hit && !misaligned && !illegal;
   assign be            = store_ok ? be_raw : 4'b0000;
   assign wdata_aligned = wdata << {lane, 3'b000};
   assign wr_en         = store_ok ? reg_sel : '0;
   assign rd_sel        = (read && hit) ? reg_sel : '0;

endmodule

// File: rtl/mtimer_slave.sv
// mtimer_slave: memory-mapped machine timer on the data-memory bus.
//   clk, reset_n  : clock and asynchronous active-low reset
//   mem_*_mem     : MEM-stage load/store request (address, store data, strobes, funct3)
//   mem_rdata_mem : registered read word, valid the cycle after a hit load, else 0
//   timer_int     : registered level interrupt, high while mtime >= mtimecmp
module mtimer_slave
   import mtimer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned DIV_W     = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] mem_addr_mem,
   input  logic [31:0] mem_wdata_mem,
   input  logic        mem_write_mem,
   input  logic        mem_read_mem,
   input  logic [2:0]  mem_op_mem,
   output logic [31:0] mem_rdata_mem,
   output logic        timer_int
);

   localparam logic [3:0] DIV_BE = div_byte_mask(int'(DIV_W));

   logic [NUM_REGS-1:0] wr_en;
   logic [NUM_REGS-1:0] rd_sel;
   logic [3:0]          be;
   logic [31:0]         wdata_aligned;

   logic [63:0]         mtime;
   logic [63:0]         mtimecmp;
   logic [31:0]         hi_snap;
   logic [DIV_W-1:0]    pre_cnt;
   logic                en;
   logic [DIV_W-1:0]    div;

   logic                tick_c;
   logic                div_wr_c;
   logic                en_nxt;
   logic [DIV_W-1:0]    div_nxt;
   ctrl_t               ctrl_rd;
   logic [31:0]         rd_word;

   mtimer_bus_if #(
      .BASE_ADDR(BASE_ADDR)
   ) u_bus_if (
      .addr          (mem_addr_mem),
      .wdata         (mem_wdata_mem),
      .write         (mem_write_mem),
      .read          (mem_read_mem),
      .op            (mem_op_mem),
      .wr_en         (wr_en),
      .be            (be),
      .wdata_aligned (wdata_aligned),
      .rd_sel        (rd_sel)
   );

   assign tick_c   = en && (pre_cnt == div);
   assign div_wr_c = wr_en[REG_CTRL] && ((be & DIV_BE) != 4'b0000);

   // CTRL update: only the byte lanes enabled by the store change EN / DIV bits.
   always_comb begin
      en_nxt  = en;
      div_nxt = div;
      if (wr_en[REG_CTRL]) begin
         if (be[0]) begin
            en_nxt = wdata_aligned[0];
         end
         for (int i = 0; i < int'(DIV_W); i++) begin
            if (be[2'((int'(CTRL_DIV_LSB) + i) / 8)]) begin
               div_nxt[i] = wdata_aligned[5'(int'(CTRL_DIV_LSB) + i)];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en  <= 1'b1;
         div <= '0;
      end else begin
         en  <= en_nxt;
         div <= div_nxt;
      end
   end

   // Prescaler: counts 0..DIV while enabled; any DIV write restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (div_wr_c || tick_c) begin
         pre_cnt <= '0;
      end else if (en) begin
         pre_cnt <= pre_cnt + DIV_W'(1);
      end
   end

   // mtime: a bus write to either half wins over the tick for the whole register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mtime <= '0;
      end else if (wr_en[REG_MTIME_LO]) begin
         mtime <= {mtime[63:32], be_merge(mtime[31:0], wdata_aligned, be)};
      end else if (wr_en[REG_MTIME_HI]) begin
         mtime <= {be_merge(mtime[63:32], wdata_aligned, be), mtime[31:0]};
      end else if (tick_c) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mtimecmp <= '1;
      end else if (wr_en[REG_MTIMECMP_LO]) begin
         mtimecmp[31:0] <= be_merge(mtimecmp[31:0], wdata_aligned, be);
      end else if (wr_en[REG_MTIMECMP_HI]) begin
         mtimecmp[63:32] <= be_merge(mtimecmp[63:32], wdata_aligned, be);
      end
   end

   // Reading MTIME_LO freezes the upper half so a following MTIME_HI read is coherent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_snap <= '0;
      end else if (rd_sel[REG_MTIME_LO]) begin
         hi_snap <= mtime[63:32];
      end
   end

   // Read mux over pre-edge values; zero when nothing is selected so it can be OR-ed with RAM data.
   always_comb begin
      ctrl_rd     = '0;
      ctrl_rd.en  = en;
      ctrl_rd.div = CTRL_DIV_MAX_W'(div);
      rd_word     = ({32{rd_sel[REG_MTIME_LO]}}    & mtime[31:0])
                  | ({32{rd_sel[REG_MTIME_HI]}}    & hi_snap)
                  | ({32{rd_sel[REG_MTIMECMP_LO]}} & mtimecmp[31:0])
                  | ({32{rd_sel[REG_MTIMECMP_HI]}} & mtimecmp[63:32])
                  | ({32{rd_sel[REG_CTRL]}}        & ctrl_rd);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_rdata_mem <= '0;
         timer_int     <= 1'b0;
      end else begin
         mem_rdata_mem <= rd_word;
         timer_int     <= (mtime >= mtimecmp);
      end
   end

endmodule
